// File: rtl/async_wr_frontend.sv
// rtl/async_wr_frontend.sv - write-domain front end of the async FIFO
// Two-entry skid buffer, rd_ptr synchroniser, fill level and prog_full.
module async_wr_frontend #(
    parameter int DEPTH       = 4,
    parameter int DWIDTH      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int PROG_FULL   = DEPTH - 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic              wr_clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [AW:0]       rd_ptr,
    output logic [AW:0]       rd_ptr_wsync,
    input  logic [AW:0]       wr_ptr,
    input  logic              wr_full,
    output logic              wr_en,
    output logic [DWIDTH-1:0] wr_data,
    output logic [AW:0]       wr_level,
    output logic              prog_full
);

    localparam logic [AW+1:0] PROG_FULL_W = (AW+2)'(PROG_FULL);

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain: the gray encoding makes each stage safe to sample.
    logic [AW:0] sync_q [SYNC_STAGES];

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rd_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rd_ptr_wsync = sync_q[SYNC_STAGES-1];

    logic [DWIDTH-1:0] ent0_q, ent0_d;
    logic [DWIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              s_ready_q;
    logic              push, pop;

    assign push = s_valid & s_ready_q;
    assign pop  = (cnt_q != 2'd0) & ~wr_full;

    // ent0 is always the head; ent1 only holds the second beat when full.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = s_data;
                end else begin
                    ent1_d = s_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = s_data;
                end else begin
                    ent0_d = s_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            ent0_q    <= '0;
            ent1_q    <= '0;
            cnt_q     <= 2'd0;
            s_ready_q <= 1'b0;
        end else begin
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            cnt_q     <= cnt_d;
            s_ready_q <= (cnt_d < 2'd2);
        end
    end

    assign s_ready = s_ready_q;
    assign wr_en   = (cnt_q != 2'd0);
    assign wr_data = ent0_q;

    logic [AW:0]   level_comb;
    logic [AW+1:0] fill_sum;
    logic [AW:0]   level_q;
    logic          prog_full_q;

    // Modulo subtract of the extended pointers absorbs wrap-around.
    assign level_comb = gray2bin(wr_ptr) - gray2bin(rd_ptr_wsync);
    assign fill_sum   = {1'b0, level_comb} + {{AW{1'b0}}, cnt_d};

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            level_q     <= '0;
            prog_full_q <= 1'b0;
        end else begin
            level_q     <= level_comb;
            prog_full_q <= (fill_sum >= PROG_FULL_W);
        end
    end

    assign wr_level  = level_q;
    assign prog_full = prog_full_q;

endmodule

// File: tb/tb_async_wr_frontend.sv
// tb/tb_async_wr_frontend.sv - self-checking bench for async_wr_frontend
// Queue-based reference model plus a bench-side write controller.
module tb_async_wr_frontend;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int SS    = 2;
    localparam int PF    = DEPTH - 1;
    localparam int AW    = 2;
    localparam int MASK  = 7;

    logic          wr_clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW:0]   rd_ptr = '0;
    logic [AW:0]   rd_ptr_wsync;
    logic [AW:0]   wr_ptr = '0;
    logic          wr_full = 1'b0;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [AW:0]   wr_level;
    logic          prog_full;

    always #5 wr_clk = ~wr_clk;

    async_wr_frontend #(.DEPTH(DEPTH), .DWIDTH(DW), .SYNC_STAGES(SS), .PROG_FULL(PF)) dut (
        .wr_clk(wr_clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .rd_ptr(rd_ptr), .rd_ptr_wsync(rd_ptr_wsync), .wr_ptr(wr_ptr), .wr_full(wr_full),
        .wr_en(wr_en), .wr_data(wr_data), .wr_level(wr_level), .prog_full(prog_full)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [DW-1:0] bq[$];
    logic [AW:0]   pipe[$];
    logic          m_ready, m_pf, m_push, m_pop;
    logic [AW:0]   m_sync, m_level;
    int            wcnt, rcnt;
    bit            ctrl, rd_auto, rd_fast, extra_stall;

    function automatic int g2b(input logic [AW:0] g);
        int b = 0;
        for (int i = AW; i >= 0; i--) begin
            b = (b << 1) | (((b & 1) ^ int'(g[i])) & 1);
        end
        return b;
    endfunction

    function automatic logic [AW:0] b2g(input int b);
        int v = b & MASK;
        return 3'(v ^ (v >> 1));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        bq.delete();
        pipe.delete();
        for (int i = 0; i < SS; i++) pipe.push_back('0);
        m_ready = 0; m_pf = 0; m_sync = '0; m_level = '0;
        m_push = 0; m_pop = 0;
        wcnt = 0; rcnt = 0;
    endtask

    task automatic model_update();
        int lvl;
        if (rst) begin
            model_reset();
        end else begin
            lvl = ((g2b(wr_ptr) - g2b(m_sync)) & MASK);
            m_push = s_valid && m_ready;
            m_pop  = (bq.size() != 0) && !wr_full;
            if (m_pop) begin
                void'(bq.pop_front());
                if (ctrl) wcnt++;
            end
            if (m_push) bq.push_back(s_data);
            m_ready = (bq.size() < 2);
            m_level = 3'(lvl);
            m_pf    = (lvl + bq.size()) >= PF;
            pipe.push_back(rd_ptr);
            void'(pipe.pop_front());
            m_sync = pipe[0];
        end
    endtask

    task automatic compare();
        chk("s_ready", s_ready, m_ready);
        chk("wr_en", wr_en, bq.size() != 0);
        if (bq.size() != 0) chk("wr_data", wr_data, bq[0]);
        chk("rd_ptr_wsync", rd_ptr_wsync, m_sync);
        chk("wr_level", wr_level, m_level);
        chk("prog_full", prog_full, m_pf);
    endtask

    task automatic drive_ctrl();
        int diff;
        if (rd_fast) rcnt = wcnt;
        else if (rd_auto && rcnt < wcnt && $urandom_range(0, 1) == 1) rcnt++;
        wr_ptr = b2g(wcnt);
        rd_ptr = b2g(rcnt);
        diff = ((wcnt & MASK) - g2b(m_sync)) & MASK;
        wr_full = (diff >= DEPTH) || (extra_stall && $urandom_range(0, 3) == 0);
    endtask

    task automatic tick();
        model_update();
        @(posedge wr_clk);
        @(negedge wr_clk);
        compare();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, sent, first, last, hi_cnt, w0;
        logic [DW-1:0] cval;
        model_reset();
        ctrl = 0; rd_auto = 0; rd_fast = 0; extra_stall = 0;
        @(negedge wr_clk);

        // Test 1: reset with s_valid high
        rst = 1; s_valid = 1; s_data = 32'hDEAD_BEEF;
        repeat (3) tick();
        chk("t1_s_ready", s_ready, 0);
        chk("t1_wr_en", wr_en, 0);
        chk("t1_wr_level", wr_level, 0);
        chk("t1_prog_full", prog_full, 0);
        chk("t1_wr_data", wr_data, 0);
        rst = 0;
        tick();
        chk("t1_s_ready_rel", s_ready, 1);

        // Test 2: fill with A0..A5, reader stalled
        ctrl = 1; idx = 0;
        for (int c = 0; c < 12; c++) begin
            drive_ctrl();
            s_valid = (idx < 6);
            s_data  = 32'hA000_0000 + idx;
            tick();
            if (m_push) idx++;
        end
        chk("t2_sent", idx, 6);
        chk("t2_written", wcnt, 4);
        chk("t2_wr_full", wr_full, 1);
        chk("t2_wr_level", wr_level, 4);
        chk("t2_prog_full", prog_full, 1);
        chk("t2_s_ready", s_ready, 0);
        chk("t2_head", wr_data, 32'hA000_0004);

        // Test 3: one read frees a slot
        s_valid = 0;
        rcnt = 1;
        drive_ctrl(); tick();
        drive_ctrl(); tick();
        chk("t3_wsync", rd_ptr_wsync, 3'b001);
        drive_ctrl(); tick();
        chk("t3_level3", wr_level, 3);
        chk("t3_s_ready", s_ready, 1);
        drive_ctrl(); tick();
        chk("t3_level4", wr_level, 4);
        chk("t3_head", wr_data, 32'hA000_0005);

        // Test 4: streaming with no backpressure
        rst = 1; drive_ctrl(); tick();
        rst = 0; rd_fast = 1; drive_ctrl(); tick();
        sent = 0; first = -1; last = -1; hi_cnt = 0; w0 = wcnt;
        for (int c = 0; c < 40; c++) begin
            drive_ctrl();
            s_valid = (sent < 16);
            s_data  = $urandom;
            tick();
            if (m_push) sent++;
            if (bq.size() > 1) chk("t4_depth", bq.size(), 1);
            if (wr_en) begin
                hi_cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("t4_written", wcnt - w0, 16);
        chk("t4_wr_en_cycles", hi_cnt, 16);
        chk("t4_contiguous", last - first, 15);
        rd_fast = 0;

        // Test 5: pointer wrap, wr=gray(1), rd=gray(7)
        ctrl = 0; s_valid = 0;
        rst = 1; tick();
        rst = 0; wr_full = 1; wr_ptr = 3'b001; rd_ptr = 3'b100;
        repeat (4) tick();
        chk("t5_wsync", rd_ptr_wsync, 3'b100);
        chk("t5_wr_level", wr_level, 2);

        // Test 6: reset with two beats held in the skid
        rst = 1; tick();
        rst = 0; wr_full = 1; wr_ptr = '0; rd_ptr = '0; s_valid = 1;
        for (int c = 0; c < 4; c++) begin
            s_data = 32'hB000_0000 + c;
            tick();
        end
        chk("t6_full_skid", s_ready, 0);
        chk("t6_wr_en_pre", wr_en, 1);
        rst = 1; s_valid = 0; tick();
        chk("t6_wr_en_rst", wr_en, 0);
        rst = 0; wr_full = 0; tick();
        chk("t6_no_stale", wr_en, 0);
        chk("t6_s_ready", s_ready, 1);
        cval = 32'hC0DE_0001;
        s_valid = 1; s_data = cval; tick();
        chk("t6_first_beat", wr_data, cval);
        chk("t6_first_en", wr_en, 1);
        s_valid = 0; tick();

        // Random phase
        rst = 1; tick();
        rst = 0;
        ctrl = 1; rd_auto = 1; extra_stall = 1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive_ctrl();
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
